tff_toggle_arbiter: RTL

//  Shares one bank of WIDTH T flip-flops between NREQ requesters. Each requester submits a toggle mask.
//  A round-robin arbiter grants one requester at a time and drives the bank's T inputs for exactly one cycle.
//  It then samples the bank's Q outputs and returns them to the granted requester with its ID.
//  The block sits between requester logic and the T-FF bank. The bank shares clk/rst with this block.

---
 rtl/tff_toggle_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter sharing one T flip-flop bank between several requesters:
// grant, drive the toggle mask for one cycle, then return the sampled bank state.
module tff_toggle_arbiter #(
    parameter int NREQ = 4,
    parameter int WIDTH = 8,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_mask,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        t_out,
    input  logic [WIDTH-1:0]        q_in,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_q,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        TOGGLE,
        SAMPLE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   idx;
    logic [IDW:0]     idx_wide;
    logic             has_winner;
    logic [WIDTH-1:0] win_mask;
    logic [WIDTH-1:0] mask_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            mask_arr[i] = req_mask[i*WIDTH +: WIDTH];
        end
    end

    // Scan from ptr upward with wrap-around; the first valid requester wins.
    always_comb begin
        has_winner = 1'b0;
        winner     = '0;
        win_mask   = '0;
        idx_wide   = '0;
        idx        = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_wide = {1'b0, ptr} + (IDW+1)'(k);
            if (idx_wide >= (IDW+1)'(NREQ)) begin
                idx_wide = idx_wide - (IDW+1)'(NREQ);
            end
            idx = idx_wide[IDW-1:0];
            if (!has_winner && req_valid[idx]) begin
                has_winner = 1'b1;
                winner     = idx;
                win_mask   = mask_arr[idx];
            end
        end
    end

    // Grant is only offered while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && has_winner && !rst) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (has_winner) state_next = TOGGLE;
            TOGGLE:  state_next = SAMPLE;
            SAMPLE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            id        <= '0;
            t_out     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (has_winner) begin
                        id    <= winner;
                        t_out <= win_mask;
                        ptr   <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
                    end
                end
                TOGGLE: begin
                    t_out <= '0;
                end
                SAMPLE: begin
                    rsp_q     <= q_in;
                    rsp_id    <= id;
                    rsp_valid <= 1'b1;
                end
                default: begin
                    t_out <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
